// File: rtl/adc_measure_responder.sv
// ----------------------------------------------------------------------------
// adc_measure_responder
//
// Sequencer for a multi-slope integrating ADC measurement. A trigger from the
// acquisition sequencer starts one measurement: the integrator is shorted for
// a programmable time, then the run-up phase applies the POS or NEG reference
// one modulation period at a time (chosen from the comparator so the
// integrator is pushed back towards zero), and finally the rundown phase
// applies a single reference until the comparator changes sign. The number of
// run-up periods spent on each reference and the rundown length are reported
// as the result.
//
// Ports
//   clk                     sole clock, all logic on the rising edge
//   reset_n                 asynchronous active-low reset
//   adc_measure_trig_i      measurement request (level, handshaken by valid)
//   p_clk_count_reset_i     integrator-reset duration, in clocks (+1)
//   p_clk_count_aperture_i  run-up aperture, in clocks
//   comparator_i            integrator sign, 1 = positive, already synchronised
//   adc_measure_valid_o     1 = idle with a result available, 0 = busy
//   sw_int_reset_o          integrator reset switch, 1 = shorted
//   refmux_o                reference select: 00 none, 01 POS, 10 NEG
//   count_pos_o/count_neg_o run-up periods spent on POS / NEG
//   count_rundown_o         rundown length in clocks
//   status_o                bit0 rundown timeout, bit1 counter saturation
// ----------------------------------------------------------------------------
module adc_measure_responder #(
    parameter int P_RUNUP_PERIOD = 20,
    parameter int P_RUNDOWN_MAX  = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_measure_trig_i,
    input  logic [23:0] p_clk_count_reset_i,
    input  logic [31:0] p_clk_count_aperture_i,
    input  logic        comparator_i,
    output logic        adc_measure_valid_o,
    output logic        sw_int_reset_o,
    output logic [1:0]  refmux_o,
    output logic [23:0] count_pos_o,
    output logic [23:0] count_neg_o,
    output logic [23:0] count_rundown_o,
    output logic [1:0]  status_o
);

    localparam logic [1:0]  REF_NONE = 2'b00;
    localparam logic [1:0]  REF_POS  = 2'b01;
    localparam logic [1:0]  REF_NEG  = 2'b10;
    localparam logic [23:0] CNT_MAX  = 24'hFFFFFF;

    localparam int                PH_W      = (P_RUNUP_PERIOD > 2) ? $clog2(P_RUNUP_PERIOD) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(P_RUNUP_PERIOD - 1);
    localparam logic [32:0]       RD_MAX_W  = 33'(P_RUNDOWN_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_RESET,
        S_RUNUP,
        S_RUNDOWN,
        S_DONE
    } state_t;

    state_t            state;

    // One timer serves all phases: integrator-reset hold, run-up elapsed
    // clocks and rundown timeout. It is cleared on every phase entry.
    logic [31:0]       tmr;
    logic [32:0]       tmr_inc;
    logic [PH_W-1:0]   phase;
    logic [23:0]       pos_cnt;
    logic [23:0]       neg_cnt;
    logic [23:0]       rd_cnt;
    logic              rd_sample;
    logic              timeout_flag;
    logic              sat_flag;

    logic              reset_done;
    logic              period_end;
    logic              aperture_done;
    logic              start_period;

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + 24'd1;
    endfunction

    // A counter is flagged as saturated once an increment leaves it at its
    // ceiling; further increments are then held off by sat_inc.
    function automatic logic hits_max(input logic [23:0] v);
        hits_max = (v >= CNT_MAX - 24'd1);
    endfunction

    assign tmr_inc       = {1'b0, tmr} + 33'd1;
    assign reset_done    = (tmr >= {8'd0, p_clk_count_reset_i});
    assign period_end    = (phase == PH_LAST);
    // Compared against the clock count including the current one, so the
    // decision lands exactly on the period boundary edge.
    assign aperture_done = (tmr_inc >= {1'b0, p_clk_count_aperture_i});

    // A new run-up period begins either on the edge leaving the integrator
    // reset or on a period boundary that has not yet covered the aperture.
    assign start_period  = ((state == S_INT_RESET) && reset_done) ||
                           ((state == S_RUNUP) && period_end && !aperture_done);

    // Measurement sequencer. All outputs are registered here; the period-start
    // block after the case statement is shared by the first run-up period and
    // every subsequent one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            adc_measure_valid_o <= 1'b1;
            sw_int_reset_o      <= 1'b1;
            refmux_o            <= REF_NONE;
            count_pos_o         <= '0;
            count_neg_o         <= '0;
            count_rundown_o     <= '0;
            status_o            <= '0;
            tmr                 <= '0;
            phase               <= '0;
            pos_cnt             <= '0;
            neg_cnt             <= '0;
            rd_cnt              <= '0;
            rd_sample           <= 1'b0;
            timeout_flag        <= 1'b0;
            sat_flag            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (adc_measure_trig_i) begin
                        adc_measure_valid_o <= 1'b0;
                        sw_int_reset_o      <= 1'b1;
                        refmux_o            <= REF_NONE;
                        tmr                 <= '0;
                        phase               <= '0;
                        pos_cnt             <= '0;
                        neg_cnt             <= '0;
                        rd_cnt              <= '0;
                        timeout_flag        <= 1'b0;
                        sat_flag            <= 1'b0;
                        state               <= S_INT_RESET;
                    end
                end

                S_INT_RESET: begin
                    if (reset_done) begin
                        sw_int_reset_o <= 1'b0;
                        tmr            <= '0;
                        state          <= S_RUNUP;
                    end else begin
                        tmr <= tmr_inc[31:0];
                    end
                end

                S_RUNUP: begin
                    tmr <= tmr_inc[31:0];
                    if (period_end) begin
                        if (aperture_done) begin
                            // The rundown reference opposes the integrator
                            // sign seen on this same edge.
                            rd_sample <= comparator_i;
                            refmux_o  <= comparator_i ? REF_NEG : REF_POS;
                            tmr       <= '0;
                            state     <= S_RUNDOWN;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end

                S_RUNDOWN: begin
                    if (comparator_i != rd_sample) begin
                        // Zero crossing: the crossing clock itself is not counted.
                        refmux_o <= REF_NONE;
                        state    <= S_DONE;
                    end else begin
                        rd_cnt <= sat_inc(rd_cnt);
                        if (hits_max(rd_cnt)) begin
                            sat_flag <= 1'b1;
                        end
                        tmr <= tmr_inc[31:0];
                        if (tmr_inc >= RD_MAX_W) begin
                            timeout_flag <= 1'b1;
                            refmux_o     <= REF_NONE;
                            state        <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Internal results are stable here, so republishing them on
                    // every DONE clock is the same as capturing them on entry.
                    count_pos_o     <= pos_cnt;
                    count_neg_o     <= neg_cnt;
                    count_rundown_o <= rd_cnt;
                    status_o        <= {sat_flag, timeout_flag};
                    if (!adc_measure_trig_i) begin
                        adc_measure_valid_o <= 1'b1;
                        state               <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (start_period) begin
                phase <= '0;
                if (comparator_i) begin
                    refmux_o <= REF_NEG;
                    neg_cnt  <= sat_inc(neg_cnt);
                    if (hits_max(neg_cnt)) begin
                        sat_flag <= 1'b1;
                    end
                end else begin
                    refmux_o <= REF_POS;
                    pos_cnt  <= sat_inc(pos_cnt);
                    if (hits_max(pos_cnt)) begin
                        sat_flag <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_measure_responder.sv
// ----------------------------------------------------------------------------
// tb_adc_measure_responder
//
// Drives complete measurements with random comparator activity and compares
// the responder against a timeline model: the number of run-up periods is
// ceil(aperture/period) (at least one), each period's reference follows the
// comparator at its start, rundown lasts until the comparator flips or the
// timeout, and results appear with valid once the trigger is released.
// ----------------------------------------------------------------------------
module tb_adc_measure_responder;

    localparam int P      = 20;
    localparam int RD_MAX = 4096;

    localparam logic [1:0] REF_NONE = 2'b00;
    localparam logic [1:0] REF_POS  = 2'b01;
    localparam logic [1:0] REF_NEG  = 2'b10;

    logic        clk;
    logic        reset_n;
    logic        trig;
    logic [23:0] p_clk_count_reset_i;
    logic [31:0] p_clk_count_aperture_i;
    logic        comparator_i;
    logic        adc_measure_valid_o;
    logic        sw_int_reset_o;
    logic [1:0]  refmux_o;
    logic [23:0] count_pos_o;
    logic [23:0] count_neg_o;
    logic [23:0] count_rundown_o;
    logic [1:0]  status_o;

    int          pass_count;
    int          check_count;

    // Results of the most recent run_measure call (model and observed).
    int          trace_err;
    int          first_bad;
    int          exp_pos_i;
    int          exp_neg_i;
    logic [23:0] exp_rd;
    logic [1:0]  exp_st;
    logic [23:0] obs_pos;
    logic [23:0] obs_neg;
    logic [23:0] obs_rd;
    logic [1:0]  obs_st;

    // Last published result, which the outputs must hold during a measurement.
    logic [23:0] prev_pos;
    logic [23:0] prev_neg;
    logic [23:0] prev_rd;
    logic [1:0]  prev_st;

    adc_measure_responder #(
        .P_RUNUP_PERIOD (P),
        .P_RUNDOWN_MAX  (RD_MAX)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .adc_measure_trig_i     (trig),
        .p_clk_count_reset_i    (p_clk_count_reset_i),
        .p_clk_count_aperture_i (p_clk_count_aperture_i),
        .comparator_i           (comparator_i),
        .adc_measure_valid_o    (adc_measure_valid_o),
        .sw_int_reset_o         (sw_int_reset_o),
        .refmux_o               (refmux_o),
        .count_pos_o            (count_pos_o),
        .count_neg_o            (count_neg_o),
        .count_rundown_o        (count_rundown_o),
        .status_o               (status_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full measurement, edge by edge. Edge 0 is the trigger edge; the
    // comparator for each edge is driven just before it and the outputs are
    // sampled 1 time unit after it. d is the number of rundown clocks before
    // the comparator flips (d >= RD_MAX never flips in time). hold is the
    // number of DONE clocks with the trigger still high; post is the number
    // of idle clocks checked afterwards.
    task automatic run_measure(input int n_rst, input int aper, input int d, input int hold,
                               input bit rand_trig, input bit toggle_cmp, input int post);
        int         periods;
        int         s0;
        int         r_entry;
        int         exit_edge;
        int         last_edge;
        bit         v;
        bit         entry_v;
        bit         cur_v;
        bit         bad;
        logic [1:0] ref_exp;
        periods   = (aper == 0) ? 1 : (aper + P - 1) / P;
        s0        = n_rst + 1;
        r_entry   = s0 + periods * P;
        exit_edge = (d < RD_MAX) ? r_entry + d + 1 : r_entry + RD_MAX;
        last_edge = exit_edge + hold + 1 + post;
        exp_pos_i = 0;
        exp_neg_i = 0;
        exp_rd    = (d < RD_MAX) ? 24'(d) : 24'(RD_MAX);
        exp_st    = (d < RD_MAX) ? 2'b00 : 2'b01;
        trace_err = 0;
        first_bad = -1;
        entry_v   = 1'b0;
        cur_v     = 1'b0;
        p_clk_count_reset_i    = 24'(n_rst);
        p_clk_count_aperture_i = 32'(aper);
        for (int e = 0; e <= last_edge; e++) begin
            if (e == 0)
                trig = 1'b1;
            else if (e <= exit_edge)
                trig = rand_trig ? 1'($urandom_range(0, 1)) : 1'b1;
            else if (e <= exit_edge + hold)
                trig = 1'b1;
            else
                trig = 1'b0;
            v = 1'($urandom_range(0, 1));
            if (e >= s0 && e < r_entry && ((e - s0) % P) == 0) begin
                if (toggle_cmp) v = 1'(((e - s0) / P) % 2);
                cur_v = v;
                if (v) exp_neg_i++;
                else   exp_pos_i++;
            end else if (e == r_entry) begin
                entry_v = v;
            end else if (e > r_entry) begin
                v = (e >= r_entry + d + 1) ? !entry_v : entry_v;
            end
            comparator_i = v;
            @(posedge clk);
            #1;
            if (e < s0)             ref_exp = REF_NONE;
            else if (e < r_entry)   ref_exp = cur_v ? REF_NEG : REF_POS;
            else if (e < exit_edge) ref_exp = entry_v ? REF_NEG : REF_POS;
            else                    ref_exp = REF_NONE;
            bad = (refmux_o !== ref_exp);
            if (e < exit_edge && sw_int_reset_o !== (e < s0)) bad = 1'b1;
            if (adc_measure_valid_o !== (e > exit_edge + hold)) bad = 1'b1;
            if (e <= exit_edge) begin
                if ({count_pos_o, count_neg_o, count_rundown_o, status_o} !==
                    {prev_pos, prev_neg, prev_rd, prev_st}) bad = 1'b1;
            end else begin
                if ({count_pos_o, count_neg_o, count_rundown_o, status_o} !==
                    {24'(exp_pos_i), 24'(exp_neg_i), exp_rd, exp_st}) bad = 1'b1;
            end
            if (bad) begin
                trace_err++;
                if (first_bad < 0) first_bad = e;
            end
        end
        obs_pos  = count_pos_o;
        obs_neg  = count_neg_o;
        obs_rd   = count_rundown_o;
        obs_st   = status_o;
        prev_pos = 24'(exp_pos_i);
        prev_neg = 24'(exp_neg_i);
        prev_rd  = exp_rd;
        prev_st  = exp_st;
    endtask

    task automatic test_reset();
        reset_n                = 1'b0;
        trig                   = 1'b0;
        comparator_i           = 1'b0;
        p_clk_count_reset_i    = '0;
        p_clk_count_aperture_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_count++;
        if ({adc_measure_valid_o, sw_int_reset_o, refmux_o} !== 4'b1100)
            $display("[TB] FAIL reset_ctrl: valid/sw/refmux=%b, want 1100", {adc_measure_valid_o, sw_int_reset_o, refmux_o});
        else pass_count++;
        check_count++;
        if ({count_pos_o, count_neg_o, count_rundown_o, status_o} !== 74'd0)
            $display("[TB] FAIL reset_counts: pos=%0d neg=%0d rd=%0d st=%b, want all 0", count_pos_o, count_neg_o, count_rundown_o, status_o);
        else pass_count++;
        prev_pos = '0; prev_neg = '0; prev_rd = '0; prev_st = '0;
        // Release away from the edge; the very next edge may take a trigger.
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        run_measure(10, 100, 50, 3, 1'b1, 1'b1, 3);
        check_count++;
        if (trace_err !== 0)
            $display("[TB] FAIL basic_trace: %0d bad cycles (first edge %0d), want 0", trace_err, first_bad);
        else pass_count++;
        check_count++;
        if (obs_pos + obs_neg !== 24'd5)
            $display("[TB] FAIL basic_periods: pos+neg=%0d, want 5", obs_pos + obs_neg);
        else pass_count++;
        check_count++;
        if ({obs_pos, obs_neg} !== {24'd3, 24'd2})
            $display("[TB] FAIL basic_split: pos=%0d neg=%0d, want pos=3 neg=2", obs_pos, obs_neg);
        else pass_count++;
        check_count++;
        if ({obs_rd, obs_st} !== {24'd50, 2'b00})
            $display("[TB] FAIL basic_rundown: rd=%0d st=%b, want rd=50 st=00", obs_rd, obs_st);
        else pass_count++;
    endtask

    task automatic test_aperture_zero();
        run_measure(0, 0, 12, 0, 1'b1, 1'b0, 2);
        check_count++;
        if (trace_err !== 0)
            $display("[TB] FAIL ap0_trace: %0d bad cycles (first edge %0d), want 0", trace_err, first_bad);
        else pass_count++;
        check_count++;
        if (obs_pos + obs_neg !== 24'd1)
            $display("[TB] FAIL ap0_periods: pos+neg=%0d, want 1", obs_pos + obs_neg);
        else pass_count++;
    endtask

    task automatic test_rundown_37();
        run_measure(4, 45, 37, 1, 1'b1, 1'b0, 2);
        check_count++;
        if (trace_err !== 0)
            $display("[TB] FAIL rd37_trace: %0d bad cycles (first edge %0d), want 0", trace_err, first_bad);
        else pass_count++;
        check_count++;
        if ({obs_rd, obs_st} !== {24'd37, 2'b00})
            $display("[TB] FAIL rd37_count: rd=%0d st=%b, want rd=37 st=00", obs_rd, obs_st);
        else pass_count++;
        check_count++;
        if ({obs_pos, obs_neg} !== {24'(exp_pos_i), 24'(exp_neg_i)})
            $display("[TB] FAIL rd37_runup: pos=%0d neg=%0d, want pos=%0d neg=%0d", obs_pos, obs_neg, exp_pos_i, exp_neg_i);
        else pass_count++;
    endtask

    task automatic test_timeout();
        run_measure(2, 30, RD_MAX + 100, 0, 1'b0, 1'b0, 2);
        check_count++;
        if (trace_err !== 0)
            $display("[TB] FAIL timeout_trace: %0d bad cycles (first edge %0d), want 0", trace_err, first_bad);
        else pass_count++;
        check_count++;
        if ({obs_rd, obs_st} !== {24'(RD_MAX), 2'b01})
            $display("[TB] FAIL timeout_result: rd=%0d st=%b, want rd=%0d st=01", obs_rd, obs_st, RD_MAX);
        else pass_count++;
        check_count++;
        if (refmux_o !== REF_NONE)
            $display("[TB] FAIL timeout_refmux: refmux=%b, want 00", refmux_o);
        else pass_count++;
    endtask

    task automatic test_rundown_boundary();
        // Flip on the last clock before the timeout would fire.
        run_measure(1, 20, RD_MAX - 1, 0, 1'b1, 1'b0, 2);
        check_count++;
        if (trace_err !== 0)
            $display("[TB] FAIL rdmax1_trace: %0d bad cycles (first edge %0d), want 0", trace_err, first_bad);
        else pass_count++;
        check_count++;
        if ({obs_rd, obs_st} !== {24'(RD_MAX - 1), 2'b00})
            $display("[TB] FAIL rdmax1_result: rd=%0d st=%b, want rd=%0d st=00", obs_rd, obs_st, RD_MAX - 1);
        else pass_count++;
    endtask

    task automatic test_trig_hold();
        run_measure(3, 60, 20, 1000, 1'b0, 1'b0, 20);
        check_count++;
        if (trace_err !== 0)
            $display("[TB] FAIL trighold_trace: %0d bad cycles (first edge %0d), want 0", trace_err, first_bad);
        else pass_count++;
        check_count++;
        if ({obs_pos + obs_neg, obs_rd} !== {24'd3, 24'd20})
            $display("[TB] FAIL trighold_result: periods=%0d rd=%0d, want periods=3 rd=20", obs_pos + obs_neg, obs_rd);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_measure(i, 20 * i + 7, 5 + i, 0, 1'b1, 1'b0, 0);
            check_count++;
            if (trace_err !== 0)
                $display("[TB] FAIL b2b_trace_%0d: %0d bad cycles (first edge %0d), want 0", i, trace_err, first_bad);
            else pass_count++;
        end
        check_count++;
        if ({obs_pos + obs_neg, obs_rd} !== {24'd3, 24'd7})
            $display("[TB] FAIL b2b_last: periods=%0d rd=%0d, want periods=3 rd=7", obs_pos + obs_neg, obs_rd);
        else pass_count++;
    endtask

    task automatic test_random();
        int n_rst;
        int aper;
        int d;
        for (int i = 0; i < 6; i++) begin
            n_rst = $urandom_range(0, 12);
            aper  = $urandom_range(0, 150);
            d     = $urandom_range(0, 120);
            run_measure(n_rst, aper, d, $urandom_range(0, 5), 1'b1, 1'b0, 2);
            check_count++;
            if (trace_err !== 0)
                $display("[TB] FAIL rand_trace_%0d: %0d bad cycles (first edge %0d, rst=%0d ap=%0d d=%0d), want 0",
                         i, trace_err, first_bad, n_rst, aper, d);
            else pass_count++;
            check_count++;
            if ({obs_pos, obs_neg, obs_rd, obs_st} !== {24'(exp_pos_i), 24'(exp_neg_i), exp_rd, exp_st})
                $display("[TB] FAIL rand_result_%0d: pos=%0d neg=%0d rd=%0d st=%b, want pos=%0d neg=%0d rd=%0d st=%b",
                         i, obs_pos, obs_neg, obs_rd, obs_st, exp_pos_i, exp_neg_i, exp_rd, exp_st);
            else pass_count++;
        end
    endtask

    task automatic test_reset_mid_runup();
        bit         first_v;
        logic [1:0] ref_exp;
        p_clk_count_reset_i    = 24'd2;
        p_clk_count_aperture_i = 32'd200;
        first_v                = 1'b0;
        // Edges 0..3 cover trigger and integrator reset; edge 3 starts run-up.
        for (int e = 0; e <= 10; e++) begin
            trig         = 1'b1;
            comparator_i = 1'($urandom_range(0, 1));
            if (e == 3) first_v = comparator_i;
            @(posedge clk);
            #1;
        end
        ref_exp = first_v ? REF_NEG : REF_POS;
        check_count++;
        if ({sw_int_reset_o, refmux_o} !== {1'b0, ref_exp})
            $display("[TB] FAIL midrun_before: sw=%b refmux=%b, want sw=0 refmux=%b", sw_int_reset_o, refmux_o, ref_exp);
        else pass_count++;
        #2;
        reset_n = 1'b0;
        #1;
        check_count++;
        if ({adc_measure_valid_o, sw_int_reset_o, refmux_o} !== 4'b1100)
            $display("[TB] FAIL midrun_reset_ctrl: valid/sw/refmux=%b, want 1100", {adc_measure_valid_o, sw_int_reset_o, refmux_o});
        else pass_count++;
        check_count++;
        if ({count_pos_o, count_neg_o, count_rundown_o, status_o} !== 74'd0)
            $display("[TB] FAIL midrun_reset_counts: pos=%0d neg=%0d rd=%0d st=%b, want all 0", count_pos_o, count_neg_o, count_rundown_o, status_o);
        else pass_count++;
        prev_pos = '0; prev_neg = '0; prev_rd = '0; prev_st = '0;
        trig    = 1'b0;
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_measure(5, 40, 9, 1, 1'b1, 1'b0, 2);
        check_count++;
        if (trace_err !== 0)
            $display("[TB] FAIL after_reset_trace: %0d bad cycles (first edge %0d), want 0", trace_err, first_bad);
        else pass_count++;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        test_reset();
        test_basic();
        test_aperture_zero();
        test_rundown_37();
        test_timeout();
        test_rundown_boundary();
        test_trig_hold();
        test_back_to_back();
        test_random();
        test_reset_mid_runup();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
